// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, Rcon/RotWord helpers and key-schedule FSM states
package aes_pkg;
  localparam int NB = 4;
  localparam int NK = 4;
  localparam int NR = 10;
  localparam int WORD_W = 32;
  localparam int KEY_W = 128;
  localparam int SCHED_W = 1408;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r <= 4'd10) ? RCON[r] : 8'h00;
  endfunction
  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] x);
    return {x[23:0], x[31:24]};
  endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: four parallel AES S-box lookups on a 32-bit word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sub
);
  localparam logic [0:255][7:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub[8*b +: 8] = SBOX[word[8*b +: 8]];
  end
endmodule

// File: rtl/aes_inv_key_expansion.sv
// aes_inv_key_expansion: rebuilds the full AES-128 key schedule backwards from
// the round-10 key, one word per clock, packed exactly like KeyExpansion.
module aes_inv_key_expansion
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [KEY_W-1:0]   key_in,
  output logic               busy,
  output logic               done,
  output logic [SCHED_W-1:0] round_keys,
  output logic [KEY_W-1:0]   cipher_key
);
  localparam int WORDS = NB * (NR + 1);
  state_t state, state_nxt;
  logic [5:0] idx, src;
  logic [WORD_W-1:0] w [WORDS];
  logic [WORD_W-1:0] prev, sub, f, new_word;
  logic load;
  // src is the index i of the forward recurrence w[i] = w[i-4] ^ f(i, w[i-1])
  assign src = idx + 6'd4;
  assign prev = w[idx + 6'd3];
  aes_sub_word u_sub (.word(rot_word(prev)), .sub(sub));
  assign f = (src[1:0] == 2'd0) ? sub ^ {rcon(src[5:2]), 24'h0} : prev;
  assign new_word = w[src] ^ f;
  assign busy = (state == EXPAND);
  assign done = (state == DONE);
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    if (state == EXPAND) state_nxt = (idx == 6'd0) ? DONE : EXPAND;
    else if (start) begin
      state_nxt = EXPAND;
      load = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      for (int i = 0; i < WORDS; i++) w[i] <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        for (int i = 0; i < 4; i++) w[WORDS-4+i] <= key_in[KEY_W-1-WORD_W*i -: WORD_W];
        idx <= 6'(WORDS - 5);
      end else if (busy) begin
        w[idx] <= new_word;
        if (idx != 6'd0) idx <= idx - 6'd1;
      end
    end
  for (genvar g = 0; g < WORDS; g++) begin : g_pack
    assign round_keys[SCHED_W-1-WORD_W*g -: WORD_W] = w[g];
  end
  assign cipher_key = round_keys[SCHED_W-1 -: KEY_W];
endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// tb_aes_inv_key_expansion: directed and round-trip vectors against a forward
// key-expansion model; a done-triggered monitor checks results from a queue.
module tb_aes_inv_key_expansion;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [127:0] key_in = '0;
  logic busy, done;
  logic [1407:0] round_keys;
  logic [127:0] cipher_key;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  typedef struct {
    logic [1407:0] rk;
    logic [127:0] ck;
    int due;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic done_q = 1'b0;
  localparam logic [0:255][7:0] SB = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;

  aes_inv_key_expansion dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .round_keys(round_keys), .cipher_key(cipher_key)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Forward AES-128 KeyExpansion; Rcon is generated by repeated xtime
  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, a, e);
    end
  endtask

  task automatic chk_rk(input string nm, input logic [1407:0] a, input logic [1407:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      for (int i = 0; i < 44; i++)
        if (a[1407-32*i -: 32] !== e[1407-32*i -: 32]) begin
          $display("FAIL %s: w[%0d] got %h, required %h", nm, i, a[1407-32*i -: 32], e[1407-32*i -: 32]);
          break;
        end
    end
  endtask

  // Monitor: every rising done retires one expected result
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 with no run pending, required 0");
      end else begin
        cur = sb.pop_front();
        chk("cipher_key", cipher_key, cur.ck);
        chk_rk("round_keys", round_keys, cur.rk);
        chk("latency_cycle", 128'(cyc), 128'(cur.due));
      end
    end
    done_q = done;
  end

  task automatic run(input logic [127:0] kin, input logic [127:0] ck, input bit push);
    @(posedge clk);
    #1;
    key_in = kin;
    start = 1'b1;
    if (push) sb.push_back('{expand(ck), ck, cyc + 41});
    @(posedge clk);
    #1;
    start = 1'b0;
    key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_within_budget", 128'(done), 128'(1));
  endtask

  logic [127:0] k, fips_in, fips_ck, zero_in;
  logic [1407:0] e;
  initial begin
    fips_in = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fips_ck = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    zero_in = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk_rk("reset_round_keys", round_keys, '0);
    reset_n = 1'b1;
    run(fips_in, fips_ck, 1'b1);
    chk("busy_after_start", 128'(busy), 128'(1));
    wait_done();
    chk("fips_w4", 128'(round_keys[1407-32*4 -: 32]), 128'(32'ha0fafe17));
    chk("fips_w43", 128'(round_keys[31:0]), 128'(32'hb6630ca6));
    run(128'h651f9e7c9ad260e70845dbeece7da0cc, 128'hcbae1d16384e56a69b07111e3f2aeffa, 1'b1);
    chk("done_drops_on_restart", 128'(done), 128'(0));
    wait_done();
    run(zero_in, 128'h0, 1'b1);
    wait_done();
    chk("zero_w4", 128'(round_keys[1407-32*4 -: 32]), 128'(32'h62636363));
    run(fips_in, fips_ck, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    key_in = zero_in;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignores_start", 128'(busy), 128'(1));
    wait_done();
    run(zero_in, 128'h0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    chk("busy_before_reset", 128'(busy), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("async_reset_busy", 128'(busy), 128'(0));
    chk("async_reset_done", 128'(done), 128'(0));
    chk_rk("async_reset_round_keys", round_keys, '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(fips_in, fips_ck, 1'b1);
    wait_done();
    for (int t = 0; t < 20; t++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      e = expand(k);
      run(e[127:0], k, 1'b1);
      wait_done();
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_expansion.md
Name: aes_inv_key_expansion

Overview:
- Reverse AES-128 key schedule. Input is the final (round-10) round key; the block walks the schedule backwards one word per clock and rebuilds all 44 words, down to and including the original cipher key.
- It sits on the decryption side next to KeyExpansion. A decryptor holding only the last round key uses it to get the full schedule, in the same packing KeyExpansion produces.

Parameters:
- Nb, 4, words per state/round key.
- Nk, 4, words in cipher key; only 4 is supported.
- Nr, 10, number of rounds; only 10 is supported.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- key_in  input  128  round-10 key, words w[40..43], with w[40] in [127:96]. Sampled on the start edge only.
- busy  output  1  high while words are being derived.
- done  output  1  high when round_keys is complete; held until the next accepted start or reset.
- round_keys  output  1408  w[0] in [1407:1376] through w[43] in [31:0]; identical packing to KeyExpansion.
- cipher_key  output  128  alias of round_keys[1407:1280], i.e. w[0..3].

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE, busy=0, done=0, round_keys=0, index counter=0. Reset mid-EXPAND aborts immediately; no partial result survives.
- States:
  - IDLE: start -> load key_in into w[40..43], idx<=39, go to EXPAND.
  - EXPAND: busy=1. Each cycle writes w[idx] = w[idx+4] XOR f(idx+4, w[idx+3]), then idx<=idx-1.
    - f(i,x) = SubWord(RotWord(x)) XOR {Rcon[i/4],24'h0} when i mod 4 == 0; otherwise f(i,x) = x.
    - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
    - The write of w[0] also sets done=1, busy=0 and state=DONE on that same edge.
  - DONE: done=1 and round_keys stable. start -> same load as in IDLE, done<=0, go to EXPAND.
- Latency: the start-sampling edge is edge 0. w[39] is written on edge 1 and w[0] on edge 40, so done is visible after edge 40 (40 cycles).
- Words not yet derived during EXPAND keep their previous contents. Consumers must qualify round_keys with done.
- start while busy is ignored. key_in changes during EXPAND have no effect.
- start and reset_n deasserting on the same edge: reset wins until reset_n is released; start must then be re-presented.
- Arithmetic: pure 32-bit XOR, no carries. idx is 6 bits, counts 39 down to 0, and never wraps; EXPAND exits at idx==0.
- The S-box path is combinational inside one cycle: one word, four S-box lookups per clock.

Decomposition:
- Shared package aes_pkg holds:
  - NB/NK/NR constants;
  - WORD_W=32, KEY_W=128, SCHED_W=1408;
  - Rcon table function;
  - RotWord function;
  - the state enum {IDLE, EXPAND, DONE}.
- Sub-module aes_sub_word (4 parallel S-box instances, 32-bit in/out), reused unchanged by KeyExpansion. The top holds the FSM, index counter, word register file and output packing.

Test Plan:
- FIPS-197 vector: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, start -> done after 40 cycles, cipher_key=2b7e151628aed2a6abf7158809cf4f3c, round_keys=2b7e1516…b6630ca6 (full FIPS-197 A.1 schedule, same as forward expansion).
- Second vector: key_in=651f9e7c9ad260e70845dbeece7da0cc, start from DONE -> done drops the next cycle and rises 40 cycles later, cipher_key=cbae1d16384e56a69b07111e3f2aeffa, round_keys equals the forward expansion of that key bit-for-bit.
- Zero-key check: key_in=b4ef5bcb3e92e21123e951cf6f8f188e -> cipher_key=0, w[4]=62636363.
- Start ignored while busy: pulse start with a different key_in at cycle 10 of EXPAND -> result unchanged, done still at cycle 40.
- Reset mid-operation: drop reset_n at cycle 20 -> busy=done=0 and round_keys=0 asynchronously. Restart -> correct result 40 cycles later.
- Round trip: 20 random cipher keys through KeyExpansion, feed w[40..43] here -> round_keys match exactly.
